// File: rtl/seq_pkg.sv
// Types and constants shared by the serial pattern generator and the sequence detector.
package seq_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [3:0] DET_PATTERN = 4'b0110;
    localparam int         DET_LEN     = 4;

endpackage

// File: rtl/seq_gen_mon.sv
// Monitor on the emitted serial stream: counts overlapping DET_PATTERN hits, saturating.
module seq_gen_mon
    import seq_pkg::*;
#(
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clr,
    input  logic            bit_vld,
    input  logic            bit_in,
    output logic [CNTW-1:0] match_count
);

    localparam logic [1:0] FILL_MAX = 2'(DET_LEN - 1);

    logic [DET_LEN-2:0] hist;
    logic [1:0]         fill;
    logic               hit;

    // fill keeps the cleared history from matching as phantom leading zeros
    assign hit = bit_vld && (fill == FILL_MAX) && ({hist, bit_in} == DET_PATTERN);

    always_ff @(posedge clk) begin
        if (reset) begin
            hist        <= '0;
            fill        <= '0;
            match_count <= '0;
        end else begin
            if (clr) begin
                hist <= '0;
                fill <= '0;
            end else if (bit_vld) begin
                hist <= {hist[DET_LEN-3:0], bit_in};
                if (fill != FILL_MAX)
                    fill <= fill + 2'd1;
            end
            if (hit && (match_count != '1))
                match_count <= match_count + 1'b1;
        end
    end

endmodule

// File: rtl/seq_gen.sv
// Serial pattern transmitter: MSB-first shift-out of a loaded pattern, repeated reps+1 times.
// Optional SEQ_GEN_MATCH_CNT_EN adds the match_count port fed by seq_gen_mon.
module seq_gen
    import seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LENW  = 4,
    parameter int REPW  = 4
`ifdef SEQ_GEN_MATCH_CNT_EN
    ,
    parameter int CNTW  = 8
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [LENW-1:0]  load_len,
    input  logic [REPW-1:0]  load_reps,
    input  logic             bit_en,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done
`ifdef SEQ_GEN_MATCH_CNT_EN
    ,
    output logic [CNTW-1:0]  match_count
`endif
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] pat;
    logic [LENW-1:0]  len, bit_cnt, len_clamped;
    logic [REPW-1:0]  reps, rep_cnt;
    logic [WIDTH-1:0] pat_shift;
    logic             accept, last_bit, last_rep;

    assign accept      = load_valid && load_ready;
    assign last_bit    = (bit_cnt == len - LENW'(1));
    assign last_rep    = (rep_cnt == reps);
    assign len_clamped = ((load_len == '0) || (load_len > LENW'(WIDTH))) ? LENW'(WIDTH) : load_len;
    assign pat_shift   = pat >> (len - LENW'(1) - bit_cnt);

    always_comb begin
        state_nxt  = state;
        load_ready = (state == IDLE);
        busy       = (state == SHIFT);
        x_valid    = busy && bit_en;
        x          = x_valid && pat_shift[0];
        case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (bit_en && last_bit && last_rep) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pat     <= '0;
            len     <= '0;
            reps    <= '0;
            bit_cnt <= '0;
            rep_cnt <= '0;
            done    <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= x_valid && last_bit && last_rep;
            if (accept) begin
                pat     <= load_data;
                len     <= len_clamped;
                reps    <= load_reps;
                bit_cnt <= '0;
                rep_cnt <= '0;
            end else if (x_valid) begin
                if (!last_bit) begin
                    bit_cnt <= bit_cnt + LENW'(1);
                end else if (!last_rep) begin
                    bit_cnt <= '0;
                    rep_cnt <= rep_cnt + REPW'(1);
                end
            end
        end
    end

`ifdef SEQ_GEN_MATCH_CNT_EN
    seq_gen_mon #(.CNTW(CNTW)) u_mon (
        .clk         (clk),
        .reset       (reset),
        .clr         (accept),
        .bit_vld     (x_valid),
        .bit_in      (x),
        .match_count (match_count)
    );
`endif

endmodule

// File: tb/tb_seq_gen.sv
// Directed bench for seq_gen; match_count checks are active when SEQ_GEN_MATCH_CNT_EN is defined.
module tb_seq_gen;

    logic       clk = 1'b0;
    logic       reset, load_valid, bit_en;
    logic [7:0] load_data;
    logic [3:0] load_len, load_reps;
    logic       load_ready, x, x_valid, busy, done;
`ifdef SEQ_GEN_MATCH_CNT_EN
    logic [7:0] match_count;
`endif
    int n_vec = 0;
    int n_err = 0;
    int exp_mc = 0;

    always #5 clk = ~clk;

    seq_gen dut (
        .clk         (clk),
        .reset       (reset),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .load_len    (load_len),
        .load_reps   (load_reps),
        .bit_en      (bit_en),
        .x           (x),
        .x_valid     (x_valid),
        .busy        (busy),
        .done        (done)
`ifdef SEQ_GEN_MATCH_CNT_EN
        ,
        .match_count (match_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one load cycle, then scramble load_* to show the captured values stick
    task automatic load(input logic [7:0] d, input logic [3:0] l, input logic [3:0] r);
        load_valid = 1'b1;
        load_data  = d;
        load_len   = l;
        load_reps  = r;
        bit_en     = 1'b0;
        @(negedge clk);
        chk("load_ready", load_ready, 1);
        chk("busy_idle", busy, 0);
        @(posedge clk); #1;
        load_valid = 1'b0;
        load_data  = ~d;
        load_len   = l + 4'd1;
        load_reps  = ~r;
    endtask

    // expects n bits MSB-first from bits, then the done cycle
    task automatic emit(input logic [31:0] bits, input int n, input bit alt);
        int k = 0;
        int c = 0;
        while (k < n && c < 100) begin
            bit_en = alt ? ~c[0] : 1'b1;
            @(negedge clk);
            chk("busy", busy, 1);
            chk("load_ready_shift", load_ready, 0);
            chk("done_shift", done, 0);
            if (bit_en) begin
                chk("x_valid", x_valid, 1);
                chk($sformatf("x[%0d]", k), x, bits[n-1-k]);
                k++;
            end else begin
                chk("x_valid_hold", x_valid, 0);
                chk("x_hold", x, 0);
            end
            @(posedge clk); #1;
            c++;
        end
        if (k < n) chk("bit_timeout", k, n);
        bit_en = 1'b0;
        @(negedge clk);
        chk("done", done, 1);
        chk("busy_end", busy, 0);
        chk("load_ready_done", load_ready, 1);
        @(posedge clk); #1;
    endtask

    task automatic idle_chk();
        @(negedge clk);
        chk("done_low", done, 0);
        chk("busy_low", busy, 0);
`ifdef SEQ_GEN_MATCH_CNT_EN
        chk("match_count", match_count, exp_mc);
`endif
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1; load_valid = 1'b0; bit_en = 1'b0;
        load_data = '0; load_len = '0; load_reps = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_x", x, 0);
        chk("rst_x_valid", x_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_load_ready", load_ready, 1);
        @(posedge clk); #1;
        reset = 1'b0;

        load(8'h06, 4'd4, 4'd0);
        emit(32'b0110, 4, 1'b0);
        exp_mc += 1;
        idle_chk();

        load(8'h03, 4'd3, 4'd2);
        emit(32'b011011011, 9, 1'b0);
        exp_mc += 2;
        idle_chk();

        load(8'h06, 4'd4, 4'd0);
        emit(32'b0110, 4, 1'b1);
        exp_mc += 1;
        idle_chk();

        load(8'hA5, 4'd0, 4'd0);
        emit(32'hA5, 8, 1'b0);
        idle_chk();
        load(8'hA5, 4'd12, 4'd0);
        emit(32'hA5, 8, 1'b0);
        idle_chk();

        // abort mid-pattern
        load(8'hA5, 4'd8, 4'd0);
        bit_en = 1'b1;
        @(negedge clk); chk("abort_x0", x, 1);
        @(posedge clk); #1;
        @(negedge clk); chk("abort_x1", x, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_mc = 0;
        @(negedge clk);
        chk("abort_x", x, 0);
        chk("abort_x_valid", x_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_load_ready", load_ready, 1);
        chk("abort_done", done, 0);
        @(posedge clk); #1;
        bit_en = 1'b0;
        idle_chk();

        // load held during SHIFT is taken only at the done cycle
        load(8'h06, 4'd4, 4'd0);
        load_valid = 1'b1;
        load_data  = 8'h03;
        load_len   = 4'd3;
        load_reps  = 4'd0;
        emit(32'b0110, 4, 1'b0);
        load_valid = 1'b0;
        exp_mc += 1;
        emit(32'b011, 3, 1'b0);
        idle_chk();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
